serial_bit_feeder: RTL and testbench
====================================

Name: serial_bit_feeder

Overview:
- Parallel-to-serial feeder that sits directly upstream of the serial sequence detectors (e.g. the 1001 Mealy detector).
- Accepts WIDTH-bit words over a valid/ready handshake and emits them one bit per clock on sout. sout drives the detector's din.
- A one-entry holding buffer lets consecutive words stream with no idle bit between frames.

Parameters:
- WIDTH, 8, bits per word; legal range WIDTH >= 2.
- MSB_FIRST, 1, 1 = transmit bit WIDTH-1 first; 0 = transmit bit 0 first.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- pdata  input  WIDTH  parallel word to serialize.
- pvalid  input  1  pdata is valid.
- pready  output  1  block can accept a word this cycle; equals ~hold_full, combinational from a register.
- sout  output  1  serial bit; connects to the detector's din.
- sout_valid  output  1  sout carries a frame bit this cycle.
- frame_last  output  1  high while the last bit of a frame is on sout.

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high.
- Reset values: state=IDLE, shift register=0, bit count=0, hold buffer empty with hold data 0, sout=0, sout_valid=0, frame_last=0.
- pready reads 1 during and after reset.
- Accept event: pvalid && pready, sampled at the rising edge.
- Internal state:
  - States IDLE and SHIFT.
  - shift register of WIDTH bits.
  - count of $clog2(WIDTH) bits, holding the remaining bits after the current one.
  - hold register of WIDTH bits plus the hold_full flag.
- All outputs are registered. sout is always the current head of the shift register: the MSB when MSB_FIRST=1, the LSB otherwise.
- IDLE:
  - On an accept: load pdata into the shift register, set count=WIDTH-1, go to SHIFT, set sout_valid=1.
  - First bit latency: the word accepted at edge N has its first bit on sout during the cycle after edge N.
  - No accept: outputs stay sout=0, sout_valid=0.
- SHIFT with count != 0:
  - Each edge shifts one bit toward the output and decrements count.
  - An accept in this state writes pdata into hold and sets hold_full.
  - frame_last = 1 exactly when count == 0 after the edge.
- SHIFT with count == 0 (last bit present), priority at the edge:
  - (a) hold_full: move hold into the shift register, clear hold_full, set count=WIDTH-1, stay in SHIFT.
  - (b) otherwise, an accept on the same edge: bypass pdata straight into the shift register, set count=WIDTH-1, stay in SHIFT. hold stays empty.
  - (c) otherwise: go to IDLE with sout_valid=0, sout=0, frame_last=0.
- Back-to-back frames: cases (a) and (b) produce continuous sout_valid with no gap bit.
- Simultaneous events:
  - pready is 0 when hold_full, so an accept can never coincide with the hold being full; hold is never overwritten.
  - When hold drains on edge N (case a), pready is 1 from the cycle after edge N.
- Back-pressure: pdata and pvalid are don't-care while pready=0. A sender holding pvalid simply waits.
- Reset mid-frame: asynchronously clears all state, including any buffered word. The partial frame is lost; no further bits are emitted.
- Wrap-around: count only ever reloads to WIDTH-1; no other value is reachable.
- Shifting: shift in 0 at the vacated end.

Test Plan:
- Single word, MSB_FIRST=1: after reset, pdata=8'h99 with one accept. Required response:
  - sout=1,0,0,1,1,0,0,1 over 8 consecutive cycles with sout_valid=1.
  - frame_last=1 on the 8th bit only, then sout_valid=0.
  - A chained 1001 detector pulses dout after bit 4 and again after bit 8 (overlap).
- Back-to-back words: accept 8'hA5, then 8'h3C one cycle later. Required response:
  - 16 continuous valid bits: 10100101 followed by 00111100.
  - pready=0 from the second accept until the hold drains at the end of bit 8.
- Stall: pvalid held high with three words 8'h01, 8'h02, 8'h03. Required response:
  - The third word waits with pready=0.
  - 24 contiguous valid bits in order; no word dropped or duplicated.
- Bypass: hold empty, accept 8'hF0 exactly in the last-bit cycle of the previous frame. Required response: no gap bit, and pready stays 1 throughout.
- LSB-first: MSB_FIRST=0, pdata=8'h01. Required response: sout=1 on the first bit, then seven 0s.
- Reset mid-frame: assert reset during bit 3 of 8'hFF with a second word held. Required response:
  - sout_valid=0, sout=0 and pready=1 immediately, without waiting for a clock edge.
  - No bits are emitted after reset is released, until a new accept.

Source files
------------

// File: rtl/serial_bit_feeder.sv
// serial_bit_feeder
// Parallel-to-serial feeder for the serial sequence detectors. Words arrive
// over a valid/ready handshake and leave one bit per clock on sout. A single
// holding register lets the next word start on the cycle after the current
// word's last bit, so back-to-back frames have no idle gap.
//
// Ports:
//   clk         rising-edge clock
//   reset       asynchronous, active-high reset
//   pdata       parallel word to serialize (WIDTH bits)
//   pvalid      pdata is valid
//   pready      a word can be accepted this cycle (= ~hold_full)
//   sout        serial bit, head of the shift register
//   sout_valid  sout carries a frame bit this cycle
//   frame_last  the last bit of a frame is on sout
//
// State table:
//   IDLE  | nothing on sout; the next accept loads the shift register directly
//   SHIFT | a frame is on sout; count = bits still to follow the current one

module serial_bit_feeder #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] pdata,
  input  logic             pvalid,
  output logic             pready,
  output logic             sout,
  output logic             sout_valid,
  output logic             frame_last
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_RELOAD = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hold_full_q, hold_full_d;
  logic             valid_q, valid_d;
  logic             last_q, last_d;

  logic             accept;
  logic [WIDTH-1:0] shift_adv;

  // A full hold register is the only source of back-pressure.
  assign pready = ~hold_full_q;
  assign accept = pvalid & ~hold_full_q;

  // Move the next bit to the output end and fill the vacated end with 0.
  assign shift_adv = MSB_FIRST ? {shift_q[WIDTH-2:0], 1'b0}
                               : {1'b0, shift_q[WIDTH-1:1]};

  assign sout       = MSB_FIRST ? shift_q[WIDTH-1] : shift_q[0];
  assign sout_valid = valid_q;
  assign frame_last = last_q;

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    count_d     = count_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    valid_d     = valid_q;
    last_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          shift_d = pdata;
          count_d = CNT_RELOAD;
          state_d = SHIFT;
          valid_d = 1'b1;
        end else begin
          shift_d = '0;
          count_d = '0;
          valid_d = 1'b0;
        end
      end

      SHIFT: begin
        if (count_q != '0) begin
          shift_d = shift_adv;
          count_d = count_q - CNT_ONE;
          last_d  = (count_q == CNT_ONE);
          if (accept) begin
            hold_d      = pdata;
            hold_full_d = 1'b1;
          end
        end else if (hold_full_q) begin
          // Buffered word follows the last bit with no gap.
          shift_d     = hold_q;
          hold_full_d = 1'b0;
          count_d     = CNT_RELOAD;
        end else if (accept) begin
          // Word offered during the last bit skips the hold register.
          shift_d = pdata;
          count_d = CNT_RELOAD;
        end else begin
          state_d = IDLE;
          shift_d = '0;
          count_d = '0;
          valid_d = 1'b0;
        end
      end

      default: begin
        state_d     = IDLE;
        shift_d     = '0;
        count_d     = '0;
        hold_full_d = 1'b0;
        valid_d     = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      count_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      valid_q     <= 1'b0;
      last_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      count_q     <= count_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      valid_q     <= valid_d;
      last_q      <= last_d;
    end
  end

endmodule

// File: tb/tb_serial_bit_feeder.sv
// Bench for serial_bit_feeder: one MSB-first and one LSB-first instance, each
// checked every cycle against a bit-queue reference model.

module tb_serial_bit_feeder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [W-1:0] pdata0 = '0, pdata1 = '0;
  logic         pvalid0 = 1'b0, pvalid1 = 1'b0;
  logic         pready0, pready1;
  logic         sout0, sout1;
  logic         svalid0, svalid1;
  logic         flast0, flast1;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  serial_bit_feeder #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .reset(reset), .pdata(pdata0), .pvalid(pvalid0),
    .pready(pready0), .sout(sout0), .sout_valid(svalid0), .frame_last(flast0)
  );

  serial_bit_feeder #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .reset(reset), .pdata(pdata1), .pvalid(pvalid1),
    .pready(pready1), .sout(sout1), .sout_valid(svalid1), .frame_last(flast1)
  );

  // Reference: every accepted word appends its bits (in transmit order) to a
  // queue; each clock edge takes one bit off the front onto the output.
  // Bits still queued behind the current one exceed W-1 exactly when a word
  // is waiting in the buffer, which is when the feeder must refuse input.
  logic [1:0] q0[$];
  logic [1:0] q1[$];
  logic       e_sout0, e_val0, e_last0;
  logic       e_sout1, e_val1, e_last1;

  task automatic push_word(input int ch, input logic [W-1:0] w, input bit msb);
    logic [1:0] e;
    for (int i = 0; i < W; i++) begin
      e[1] = msb ? w[W-1-i] : w[i];
      e[0] = (i == W - 1);
      if (ch == 0) q0.push_back(e);
      else         q1.push_back(e);
    end
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s @%0t observed=%b expected=%b", tag, $time, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("msb_sout",   sout0,   e_sout0);
    chk("msb_valid",  svalid0, e_val0);
    chk("msb_last",   flast0,  e_last0);
    chk("msb_pready", pready0, (q0.size() < W));
    chk("lsb_sout",   sout1,   e_sout1);
    chk("lsb_valid",  svalid1, e_val1);
    chk("lsb_last",   flast1,  e_last1);
    chk("lsb_pready", pready1, (q1.size() < W));
  endtask

  // One clock: drive inputs, advance the model at the edge, check at negedge.
  task automatic cycle(input logic v0, input logic [W-1:0] d0,
                       input logic v1, input logic [W-1:0] d1,
                       output bit acc0, output bit acc1);
    logic [1:0] e;
    pvalid0 = v0; pdata0 = d0;
    pvalid1 = v1; pdata1 = d1;
    acc0 = v0 && (q0.size() < W);
    acc1 = v1 && (q1.size() < W);
    @(posedge clk);
    if (acc0) push_word(0, d0, 1'b1);
    if (acc1) push_word(1, d1, 1'b0);
    if (q0.size() > 0) begin
      e = q0.pop_front();
      e_sout0 = e[1]; e_last0 = e[0]; e_val0 = 1'b1;
    end else begin
      e_sout0 = 1'b0; e_last0 = 1'b0; e_val0 = 1'b0;
    end
    if (q1.size() > 0) begin
      e = q1.pop_front();
      e_sout1 = e[1]; e_last1 = e[0]; e_val1 = 1'b1;
    end else begin
      e_sout1 = 1'b0; e_last1 = 1'b0; e_val1 = 1'b0;
    end
    @(negedge clk);
    check_all();
  endtask

  task automatic idle(input int n);
    bit a0, a1;
    for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b0, '0, a0, a1);
  endtask

  initial begin
    bit a0, a1;
    logic [W-1:0] words[3];
    logic [W-1:0] rw0, rw1;
    logic         rv0, rv1;
    int           k;
    logic [7:0]   seen;

    e_sout0 = 0; e_val0 = 0; e_last0 = 0;
    e_sout1 = 0; e_val1 = 0; e_last1 = 0;

    // Reset state, with reset still asserted.
    #1;
    check_all();
    @(negedge clk);
    @(negedge clk);
    check_all();
    reset = 1'b0;
    idle(2);

    // Single 8'h99 MSB-first; 8'h01 LSB-first on the other instance.
    // The MSB stream is also checked against the literal bit pattern.
    cycle(1'b1, 8'h99, 1'b1, 8'h01, a0, a1);
    seen = '0;
    seen[7] = sout0;
    for (int i = 6; i >= 0; i--) begin
      cycle(1'b0, '0, 1'b0, '0, a0, a1);
      seen[i] = sout0;
    end
    chk("msb_99_b0", seen[7], 1'b1);
    chk("msb_99_b3", seen[4], 1'b1);
    chk("msb_99_b7", seen[0], 1'b1);
    chk("msb_99_b1", seen[6], 1'b0);
    idle(3);

    // Back-to-back A5 then 3C.
    cycle(1'b1, 8'hA5, 1'b1, 8'hA5, a0, a1);
    cycle(1'b1, 8'h3C, 1'b1, 8'h3C, a0, a1);
    idle(17);

    // Stall: pvalid held high with three words on each instance.
    words[0] = 8'h01; words[1] = 8'h02; words[2] = 8'h03;
    begin
      int i0, i1;
      i0 = 0; i1 = 0;
      while (i0 < 3 || i1 < 3) begin
        cycle(i0 < 3, (i0 < 3) ? words[i0] : '0,
              i1 < 3, (i1 < 3) ? words[i1] : '0, a0, a1);
        if (a0) i0++;
        if (a1) i1++;
      end
    end
    idle(26);

    // Bypass: F0 offered exactly in the last-bit cycle of the previous frame.
    cycle(1'b1, 8'h5A, 1'b1, 8'h5A, a0, a1);
    idle(7);
    chk("bypass_lastbit", flast0, 1'b1);
    cycle(1'b1, 8'hF0, 1'b1, 8'hF0, a0, a1);
    chk("bypass_accepted", a0, 1'b1);
    idle(10);

    // Reset during bit 3 of 8'hFF with a second word buffered.
    cycle(1'b1, 8'hFF, 1'b1, 8'hFF, a0, a1);
    cycle(1'b1, 8'hAA, 1'b1, 8'hAA, a0, a1);
    cycle(1'b0, '0, 1'b0, '0, a0, a1);
    chk("pre_reset_hold_full", pready0, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_valid", svalid0, 1'b0);
    chk("async_rst_sout",  sout0,   1'b0);
    chk("async_rst_ready", pready0, 1'b1);
    chk("async_rst_valid_lsb", svalid1, 1'b0);
    chk("async_rst_ready_lsb", pready1, 1'b1);
    q0.delete(); q1.delete();
    e_sout0 = 0; e_val0 = 0; e_last0 = 0;
    e_sout1 = 0; e_val1 = 0; e_last1 = 0;
    @(negedge clk);
    check_all();
    reset = 1'b0;
    idle(12);

    // Randomized traffic on both instances.
    for (int n = 0; n < 400; n++) begin
      rv0 = ($urandom_range(0, 3) != 0);
      rv1 = ($urandom_range(0, 3) != 0);
      rw0 = W'($urandom);
      rw1 = W'($urandom);
      cycle(rv0, rw0, rv1, rw1, a0, a1);
    end
    idle(20);

    k = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
